// File: rtl/nios2_qsys_mulx_seq.sv
// Multi-cycle 32x32->64 multiply sequencer: one 16x16 unsigned multiplier is
// time-shared over four partial products, then the high word gets a sign fix-up.
module nios2_qsys_mulx_seq #(
   parameter int MUL_LATENCY = 1   // product register stages, 1 or 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        cancel,
   input  logic [1:0]  op,
   input  logic [31:0] src1,
   input  logic [31:0] src2,
   output logic        busy,
   output logic        done,
   output logic [31:0] result_lo,
   output logic [31:0] result_hi
);

   localparam int         DATA_W   = 32;
   localparam int         HALF_W   = DATA_W / 2;
   localparam logic [2:0] LAST_CNT = 3'(3 + MUL_LATENCY);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_CORR, S_DONE} state_t;

   state_t              r_state, w_state_nxt;
   logic [2:0]          r_cnt;
   logic [DATA_W-1:0]   r_a, r_b;
   logic [1:0]          r_op;
   logic [2*DATA_W-1:0] r_acc;
   logic                w_accept, w_issue;
   logic [HALF_W-1:0]   w_mul_a, w_mul_b;
   logic [1:0]          w_sh_issue;
   logic [DATA_W-1:0]   r_prod_p0;
   logic [1:0]          r_sh_p0;
   logic                r_vld_p0;
   logic [DATA_W-1:0]   w_prod;
   logic [1:0]          w_sh;
   logic                w_vld;
   logic [2*DATA_W-1:0] w_term;

   // Unsigned high word minus the two's-complement cross terms of signed operands.
   function automatic logic [DATA_W-1:0] f_sign_corr(input logic [DATA_W-1:0] hi,
                                                     input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b,
                                                     input logic [1:0]        opc);
      logic              sa, sb;
      logic [DATA_W-1:0] ca, cb;
      sa = opc[1];
      sb = (opc == 2'b11);
      ca = (sa && a[DATA_W-1]) ? b : '0;
      cb = (sb && b[DATA_W-1]) ? a : '0;
      return hi - ca - cb;
   endfunction

   assign w_accept = (r_state == S_IDLE) && start && !cancel;
   assign w_issue  = (r_state == S_MUL) && (r_cnt < 3'd4) && !cancel;

   always_comb begin
      w_state_nxt = r_state;
      busy        = (r_state != S_IDLE);
      done        = (r_state == S_DONE);
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_MUL;
         S_MUL: begin
            if (cancel)                  w_state_nxt = S_IDLE;
            else if (r_cnt == LAST_CNT)  w_state_nxt = S_CORR;
         end
         S_CORR:  w_state_nxt = cancel ? S_IDLE : S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_vld_p0 <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_vld_p0 <= w_issue;
         if (w_accept)
            r_cnt <= '0;
         else if (r_state == S_MUL)
            r_cnt <= r_cnt + 3'd1;
      end
   end

   // Issue order: lo*lo, hi*lo, lo*hi, hi*hi; shift code 0/1/2 = 0/16/32 bits.
   always_comb begin
      w_mul_a    = r_a[HALF_W-1:0];
      w_mul_b    = r_b[HALF_W-1:0];
      w_sh_issue = 2'd0;
      case (r_cnt[1:0])
         2'd1: begin
            w_mul_a    = r_a[DATA_W-1:HALF_W];
            w_sh_issue = 2'd1;
         end
         2'd2: begin
            w_mul_b    = r_b[DATA_W-1:HALF_W];
            w_sh_issue = 2'd1;
         end
         2'd3: begin
            w_mul_a    = r_a[DATA_W-1:HALF_W];
            w_mul_b    = r_b[DATA_W-1:HALF_W];
            w_sh_issue = 2'd2;
         end
         default: ;
      endcase
   end

   // ---- stage p0: operand latch and first product register
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_a  <= src1;
         r_b  <= src2;
         r_op <= op;
      end
      r_prod_p0 <= 32'(w_mul_a) * 32'(w_mul_b);
      r_sh_p0   <= w_sh_issue;
   end

   // ---- stage p1: optional second product register
   generate
      if (MUL_LATENCY == 1) begin : g_lat1
         assign w_prod = r_prod_p0;
         assign w_sh   = r_sh_p0;
         assign w_vld  = r_vld_p0;
      end else begin : g_lat2
         logic [DATA_W-1:0] r_prod_p1;
         logic [1:0]        r_sh_p1;
         logic              r_vld_p1;
         always_ff @(posedge clk) begin
            r_prod_p1 <= r_prod_p0;
            r_sh_p1   <= r_sh_p0;
         end
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) r_vld_p1 <= 1'b0;
            else          r_vld_p1 <= r_vld_p0 && (r_state == S_MUL) && !cancel;
         end
         assign w_prod = r_prod_p1;
         assign w_sh   = r_sh_p1;
         assign w_vld  = r_vld_p1;
      end
   endgenerate

   always_comb begin
      case (w_sh)
         2'd1:    w_term = {{HALF_W{1'b0}}, w_prod, {HALF_W{1'b0}}};
         2'd2:    w_term = {w_prod, {DATA_W{1'b0}}};
         default: w_term = {{DATA_W{1'b0}}, w_prod};
      endcase
   end

   // ---- accumulate stage
   always_ff @(posedge clk) begin
      if (w_accept)
         r_acc <= '0;
      else if ((r_state == S_MUL) && w_vld)
         r_acc <= r_acc + w_term;
   end

   // ---- correction stage: results only move on CORR->DONE
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         result_lo <= '0;
         result_hi <= '0;
      end else if ((r_state == S_CORR) && !cancel) begin
         result_lo <= r_acc[DATA_W-1:0];
         result_hi <= f_sign_corr(r_acc[2*DATA_W-1:DATA_W], r_a, r_b, r_op);
      end
   end

endmodule

// File: tb/tb_nios2_qsys_mulx_seq.sv
// Bench for nios2_qsys_mulx_seq: vector table plus hand sequences for the
// busy/cancel/reset corners; one instance per multiplier latency.
module tb_nios2_qsys_mulx_seq;

   logic        clk = 1'b0;
   logic        reset_n, start, cancel, start2, en2;
   logic [1:0]  op;
   logic [31:0] src1, src2;
   logic        busy1, done1, busy2, done2;
   logic [31:0] lo1, hi1, lo2, hi2;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   typedef struct {
      logic [63:0] res;
      int          acc_cyc;
      int          lat;
   } sb_t;
   sb_t q1[$];
   sb_t q2[$];

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;
   vec_t vecs[10];

   logic [63:0] last_exp;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign start2 = start & en2;

   nios2_qsys_mulx_seq #(.MUL_LATENCY(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .start(start), .cancel(cancel), .op(op),
      .src1(src1), .src2(src2), .busy(busy1), .done(done1),
      .result_lo(lo1), .result_hi(hi1));

   nios2_qsys_mulx_seq #(.MUL_LATENCY(2)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .start(start2), .cancel(cancel), .op(op),
      .src1(src1), .src2(src2), .busy(busy2), .done(done2),
      .result_lo(lo2), .result_hi(hi2));

   function automatic logic [63:0] model(input logic [1:0] opc, input logic [31:0] a,
                                         input logic [31:0] b);
      logic signed [32:0] xa, xb;
      logic signed [65:0] p;
      xa = {opc[1] & a[31], a};
      xb = {(opc == 2'b11) & b[31], b};
      p  = xa * xb;
      return p[63:0];
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
      end
   endtask

   // Drive a request at the current negedge; it is accepted on the next edge.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit expect_done);
      sb_t e;
      op = o; src1 = a; src2 = b; start = 1'b1; cancel = 1'b0;
      if (expect_done) begin
         e.res = model(o, a, b); e.acc_cyc = cyc + 1; e.lat = 6;
         q1.push_back(e);
         last_exp = e.res;
         if (en2) begin
            e.lat = 7;
            q2.push_back(e);
         end
      end
   endtask

   task automatic wait_idle(input bit chk_busy);
      int n1, n2;
      bit idle;
      n1 = 0; n2 = 0; idle = 0;
      for (int t = 0; t < 30; t++) begin
         @(negedge clk);
         start = 1'b0; cancel = 1'b0;
         src1 = $urandom; src2 = $urandom;
         if (busy1) n1++;
         if (busy2) n2++;
         if (!busy1 && !busy2) begin
            idle = 1;
            break;
         end
      end
      if (!idle) begin
         n_chk++; n_fail++;
         $display("FAIL idle_timeout: got busy1=%0b busy2=%0b, expected both low", busy1, busy2);
      end
      if (chk_busy) begin
         chk("busy1_cycles", 64'(n1), 64'd7);
         if (en2) chk("busy2_cycles", 64'(n2), 64'd8);
      end
   endtask

   always @(negedge clk) begin
      sb_t e;
      if (done1 === 1'b1) begin
         if (q1.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL dut1_unexpected_done: got done=1 result 0x%h, expected no done", {hi1, lo1});
         end else begin
            e = q1.pop_front();
            chk("dut1_result", {hi1, lo1}, e.res);
            chk("dut1_latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
         end
      end
      if (done2 === 1'b1) begin
         if (q2.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL dut2_unexpected_done: got done=1 result 0x%h, expected no done", {hi2, lo2});
         end else begin
            e = q2.pop_front();
            chk("dut2_result", {hi2, lo2}, e.res);
            chk("dut2_latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected end of test");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0; start = 1'b0; cancel = 1'b0; op = 2'b00;
      src1 = '0; src2 = '0; en2 = 1'b0; last_exp = '0;

      vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
      vecs[1] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
      vecs[2] = '{2'b11, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
      vecs[3] = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFE};
      vecs[4] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE};
      vecs[5] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
      vecs[6] = '{2'b11, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000};
      vecs[7] = '{2'b10, 32'h0000_0003, 32'h8000_0000, 64'h0000_0001_8000_0000};
      for (int i = 8; i < 10; i++) begin
         vecs[i].op  = 2'($urandom_range(0, 3));
         vecs[i].a   = $urandom;
         vecs[i].b   = $urandom;
         vecs[i].exp = model(vecs[i].op, vecs[i].a, vecs[i].b);
      end

      repeat (2) @(negedge clk);
      chk("reset_busy", 64'(busy1), 64'd0);
      chk("reset_done", 64'(done1), 64'd0);
      chk("reset_result", {hi1, lo1}, 64'd0);
      chk("reset_busy2", 64'(busy2), 64'd0);
      reset_n = 1'b1;

      // table: both latencies run every vector side by side
      en2 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
         chk("vec_model", model(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].exp);
         wait_idle(1'b1);
      end
      en2 = 1'b0;

      // starts while busy (MUL, CORR, DONE) are ignored; restart right after is taken
      @(negedge clk);
      issue(2'b01, 32'd3, 32'd5, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         start = (k == 2 || k == 6 || k == 7);
         op    = 2'($urandom_range(0, 3));
         src1  = $urandom;
         src2  = $urandom;
         if (k == 1) chk("busy_after_accept", 64'(busy1), 64'd1);
         if (k == 8) begin
            chk("idle_before_restart", 64'(busy1), 64'd0);
            issue(2'b01, 32'h0000_1234, 32'h0000_0010, 1'b1);
         end
      end
      wait_idle(1'b1);

      // cancel mid-MUL
      @(negedge clk);
      issue(2'b01, 32'd7, 32'd9, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         start = 1'b0;
         cancel = (k == 3);
      end
      @(negedge clk);
      cancel = 1'b0;
      chk("cancel_mul_busy", 64'(busy1), 64'd0);
      repeat (10) @(negedge clk);
      chk("cancel_mul_hold", {hi1, lo1}, last_exp);

      // start together with cancel in IDLE
      start = 1'b1; cancel = 1'b1; op = 2'b01; src1 = 32'd2; src2 = 32'd2;
      @(negedge clk);
      start = 1'b0; cancel = 1'b0;
      chk("start_cancel_busy", 64'(busy1), 64'd0);
      repeat (8) @(negedge clk);
      chk("start_cancel_hold", {hi1, lo1}, last_exp);

      // cancel in CORR
      issue(2'b11, 32'd5, 32'd6, 1'b0);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         start = 1'b0;
         cancel = (k == 6);
      end
      @(negedge clk);
      cancel = 1'b0;
      chk("cancel_corr_busy", 64'(busy1), 64'd0);
      repeat (3) @(negedge clk);
      chk("cancel_corr_hold", {hi1, lo1}, last_exp);

      // cancel during DONE does not suppress the pulse
      issue(2'b00, 32'h0000_DEAD, 32'h0000_BEEF, 1'b1);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 7) begin
            chk("done_with_cancel", 64'(done1), 64'd1);
            cancel = 1'b1;
         end
      end
      wait_idle(1'b0);

      // asynchronous reset mid-MUL
      @(negedge clk);
      issue(2'b01, 32'd7, 32'd9, 1'b0);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_busy", 64'(busy1), 64'd0);
      chk("async_rst_done", 64'(done1), 64'd0);
      chk("async_rst_result", {hi1, lo1}, 64'd0);
      chk("async_rst_result2", {hi2, lo2}, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // recovery after reset, both latencies
      en2 = 1'b1;
      @(negedge clk);
      issue(vecs[0].op, vecs[0].a, vecs[0].b, 1'b1);
      wait_idle(1'b1);
      en2 = 1'b0;

      repeat (3) @(negedge clk);
      chk("q1_drained", 64'(q1.size()), 64'd0);
      chk("q2_drained", 64'(q2.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
